if_array_arbiter: RTL and testbench
===================================

# if_array_arbiter

Round-robin arbiter that shares one downstream `data`/`valid` channel among the NUM_REQ elements of an interface-instance array. Each array element drives a requester channel of 8-bit `data` plus `valid`. Per cycle, the block grants one requester, registers the winning beat into a single output stage, and forwards it downstream with a ready/valid handshake. It sits between the interface array and the single shared consumer, in the same clock domain as the interface clock.

## Interface
- NUM_REQ, 2, number of requester channels (array elements); ≥2
- DATA_W, 8, payload width per channel
- MAX_BURST, 4, beats one requester may hold the grant; used only when IF_ARB_BURST_EN is defined
- clk  input  1  interface clock; all state on rising edge
- rst_n  input  1  reset; one clock, synchronous, active-low
- req_valid  input  NUM_REQ  per-requester beat valid
- req_data  input  NUM_REQ*DATA_W  requester i payload in bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot-or-zero beat accept per requester
- out_valid  output  1  shared channel valid
- out_data  output  DATA_W  shared channel payload
- out_src  output  $clog2(NUM_REQ)  index of requester that produced out_data
- out_ready  input  1  consumer accepts the beat

## Operation
- Output stage is a single register (out_valid, out_data, out_src). FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- `accept = !out_valid || out_ready`. When accept=1 and any req_valid is set, the arbiter picks a winner g:
  - req_ready[g]=1; all other bits of req_ready are 0.
  - The beat loads the output stage: out_data=req_data[g], out_src=g.
  - The FSM goes to FULL (or stays FULL when draining and refilling in the same cycle).
- When accept=1 and no req_valid is set:
  - If out_ready was high in FULL, the FSM goes to EMPTY.
  - In EMPTY, it stays EMPTY.
- When out_valid=1 and out_ready=0, the output stage holds. req_ready is all-zero.
- Winner selection is round-robin. The search starts at index last_grant+1 and wraps from NUM_REQ-1 to 0. The first set req_valid found wins.
  - last_grant updates to g only on a transfer, i.e. req_valid[g] && req_ready[g].
- req_ready is combinational from req_valid, out_valid, out_ready and the arbiter state. Requesters must not make req_valid depend on req_ready.
- A requester that drops req_valid before it is granted loses nothing: the arbiter holds no pending state for it.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, last_grant=NUM_REQ-1 (requester 0 wins first), burst count=0, FSM=EMPTY.
- Reset mid-operation discards any beat held in the output stage.
- Latency: a beat accepted at edge N shows out_valid=1 after edge N, and is consumed at the first edge where out_ready=1.
- Throughput: one beat per cycle when out_ready stays high. A drain and a refill in the same cycle are legal and required.
- Simultaneous requests: exactly one grant per cycle. With all requesters continuously valid, grants go 0,1,…,NUM_REQ-1,0,…

## Configuration
- Macro `IF_ARB_BURST_EN`, defined: after requester g transfers, g keeps priority on following accepts while req_valid[g]=1, up to MAX_BURST consecutive beats. The grant then rotates to the next requester in round-robin order.
  - A burst counter resets whenever the grant changes or req_valid[g] drops.
  - The burst counter does not advance on cycles with accept=0.
- Macro undefined: the grant rotates after every beat, and MAX_BURST is ignored.

## Structure
- Package `if_arb_pkg` contains:
  - default DATA_W localparam;
  - FSM enum `arb_state_t` {EMPTY, FULL};
  - function `src_w(n)` that returns max(1, $clog2(n)).
- Sub-module `rr_pick`: a combinational rotating priority encoder.
  - Inputs: request vector and start index.
  - Outputs: winner index and any-valid flag.
  - The top level instantiates it once.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → out_valid=0, out_data=0, req_ready=0. After release, the first beat comes from requester 0.
- Single requester: req 1 sends 8'hCC with out_ready=1 → one cycle later out_valid=1, out_data=8'hCC, out_src=1. Next cycle out_valid=0.
- Fairness: NUM_REQ=2, both valid continuously (data 8'hBB, 8'hCC), out_ready=1 → out_src alternates 0,1,0,1 and out_valid stays high every cycle.
- Backpressure: output stage holds 8'hAA and out_ready=0 for 3 cycles → out_data stays 8'hAA, req_ready=0. On out_ready=1, the next beat loads in the same cycle.
- Burst, compiled with IF_ARB_BURST_EN and MAX_BURST=4: both requesters valid → out_src sequence is 0,0,0,0,1,1,1,1,0.
- Burst, compiled without the macro: same stimulus → out_src alternates 0,1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_data=8'hDD → after the next edge out_valid=0 and last_grant is restored so requester 0 wins next.

Source files
------------

// File: rtl/if_arb_pkg.sv
// Shared types and helpers for the interface-array round-robin arbiter.
package if_arb_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after
// start, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found_hi;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    found_hi = 1'b0;
    // Upper segment [start, N-1] has priority over the wrapped segment.
    for (int i = 0; i < N; i++) begin
      if (!found_hi && req[i] && (i >= int'(start))) begin
        found_hi = 1'b1;
        idx      = IW'(i);
      end
    end
    any = found_hi;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/if_array_arbiter.sv
// Round-robin arbiter merging NUM_REQ requester channels into one registered
// ready/valid output. Define IF_ARB_BURST_EN to let a winner keep up to MAX_BURST beats.
module if_array_arbiter
  import if_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [src_w(NUM_REQ)-1:0]    out_src,
  input  logic                         out_ready
);

  localparam int SW      = src_w(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
`ifdef IF_ARB_BURST_EN
  localparam int BURST_LIM = MAX_BURST;
`else
  // A limit of one beat means the holder never keeps priority.
  localparam int BURST_LIM = 1;
`endif

  arb_state_t          state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SW-1:0]       src_q, src_d;
  logic [SW-1:0]       last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;

  logic                accept;
  logic                hold;
  logic                xfer;
  logic                any;
  logic [SW-1:0]       start;
  logic [SW-1:0]       grant;
  logic [DATA_W-1:0]   data_sel;

  always_comb begin
    accept = (state_q == EMPTY) || out_ready;
    hold   = (burst_q != '0) && (burst_q < BURST_W'(BURST_LIM)) && req_valid[last_q];
    if (hold) begin
      start = last_q;
    end else if (last_q == SW'(NUM_REQ - 1)) begin
      start = '0;
    end else begin
      start = last_q + SW'(1);
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (SW)
  ) u_pick (
    .req   (req_valid),
    .start (start),
    .idx   (grant),
    .any   (any)
  );

  always_comb begin
    xfer     = rst_n && accept && any;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (grant == SW'(i));
      if (grant == SW'(i)) begin
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    burst_d = burst_q;
    // A dropped valid ends the holder's burst even while the output stalls.
    if (!req_valid[last_q]) begin
      burst_d = '0;
    end
    if (xfer) begin
      state_d = FULL;
      data_d  = data_sel;
      src_d   = grant;
      last_d  = grant;
      burst_d = hold ? (burst_q + BURST_W'(1)) : BURST_W'(1);
    end else if (accept) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= SW'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_if_array_arbiter.sv
// Randomized and directed bench for if_array_arbiter against a cycle-level
// reference model of the round-robin / burst grant rules.
module tb_if_array_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;

  if_array_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_src;
  int       m_last;
  int       m_burst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 0;
    m_last  = N - 1;
    m_burst = 0;
  endtask

  // Called at posedge+1 with inputs already applied; checks this cycle,
  // advances the model across the next edge and returns at posedge+1.
  task automatic step();
    int          g;
    bit          any;
    bit          hold;
    bit          accept;
    logic [N-1:0] exp_rdy;
    #3;
    accept = !m_valid || out_ready;
    hold   = 1'b0;
`ifdef IF_ARB_BURST_EN
    hold = (m_burst > 0) && (m_burst < MB) && req_valid[m_last];
`endif
    any = 1'b0;
    g   = 0;
    if (accept && rst_n) begin
      if (hold) begin
        any = 1'b1;
        g   = m_last;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (!any && req_valid[idx]) begin
            any = 1'b1;
            g   = idx;
          end
        end
      end
    end
    exp_rdy = any ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_src", 32'(out_src), 32'(m_src));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!req_valid[m_last]) m_burst = 0;
      if (any) begin
        m_burst = hold ? m_burst + 1 : 1;
        m_last  = g;
        m_valid = 1'b1;
        m_data  = req_data[g*DW +: DW];
        m_src   = g;
      end else if (accept) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef IF_ARB_BURST_EN
  int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
  int exp_seq [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = {8'h33, 8'h22, 8'h11};
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset held with every requester valid
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    rst_n = 1'b1;
    step();
    chk("first_src", 32'(out_src), 32'd0);
    chk("first_data", 32'(out_data), 32'h11);

    // Single requester
    out_ready = 1'b1;
    req_valid = 3'b000;
    step();
    req_valid = 3'b010;
    req_data  = {8'h00, 8'hCC, 8'h00};
    step();
    req_valid = 3'b000;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hCC);
    chk("single_src", 32'(out_src), 32'd1);
    step();
    chk("single_drain", 32'(out_valid), 32'd0);

    // Fairness / burst with requesters 0 and 1 continuously valid
    req_valid = 3'b011;
    req_data  = {8'h00, 8'hCC, 8'hBB};
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("seq_src%0d", i), 32'(out_src), 32'(exp_seq[i]));
      chk($sformatf("seq_valid%0d", i), 32'(out_valid), 32'd1);
    end

    // Backpressure
    req_valid = 3'b000;
    step();
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'hAA};
    out_ready = 1'b0;
    step();
    req_valid = 3'b010;
    req_data  = {8'h00, 8'h55, 8'h00};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'hAA);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_refill_data", 32'(out_data), 32'h55);
    chk("bp_refill_src", 32'(out_src), 32'd1);

    // Reset mid-stream discards the held beat
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'hDD};
    step();
    chk("mid_loaded", 32'(out_data), 32'hDD);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    req_valid = 3'b011;
    req_data  = {8'h00, 8'h02, 8'h01};
    step();
    chk("mid_rst_src", 32'(out_src), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_data  = (N*DW)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
